// File: rtl/mcp3008_scanner.sv
`default_nettype none
// ============================================================================
// Module   : mcp3008_scanner
// Purpose  : Autonomous SPI master that round-robins the enabled MCP3008
//            single-ended channels, keeps the latest 10-bit result per
//            channel and announces each stored sample and each completed scan.
// Revision : 1.0  initial release
// ============================================================================
module mcp3008_scanner #(
  parameter int         HALF_PERIOD = 25,
  parameter int         GAP_CYCLES  = 25,
  parameter logic [7:0] CH_MASK     = 8'hFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  output logic       ad_clk,
  output logic       cs_n,
  output logic       din,
  input  logic       dout,
  input  logic [2:0] rd_ch,
  output logic [9:0] rd_data,
  output logic       sample_valid,
  output logic [2:0] sample_ch,
  output logic [9:0] sample_data,
  output logic       scan_done
);

  // Lowest enabled channel: the first one addressed after reset.
  function automatic logic [2:0] lowest_ch(input logic [7:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) r = 3'(i);
    end
    return r;
  endfunction

  // Highest enabled channel: its commit closes a scan.
  function automatic logic [2:0] highest_ch(input logic [7:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) r = 3'(i);
    end
    return r;
  endfunction

  // Next enabled channel after cur, wrapping 7 -> 0; a lone channel maps to itself.
  function automatic logic [2:0] next_ch(input logic [2:0] cur, input logic [7:0] m);
    logic [2:0] r;
    logic [2:0] c;
    logic       found;
    r     = cur;
    found = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      c = cur + 3'(i);
      if (!found && m[c]) begin
        r     = c;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  localparam logic [2:0]  C_FIRST_CH   = lowest_ch(CH_MASK);
  localparam logic [2:0]  C_LAST_CH    = highest_ch(CH_MASK);
  localparam logic        C_MASK_EMPTY = (CH_MASK == 8'h00);
  localparam logic [11:0] C_HP_LAST    = 12'(HALF_PERIOD - 1);
  localparam logic [11:0] C_GAP_LAST   = 12'(GAP_CYCLES - 1);
  // A frame is 34 ad_clk half periods; event 34 is the 17th falling edge.
  localparam logic [5:0]  C_LAST_HALF  = 6'd33;
  // Rising edge 8 (first data bit B9) is half-period event 15, reached from half count 14.
  localparam logic [5:0]  C_FIRST_DATA = 6'd14;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FRAME = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] hp_cnt_q, hp_cnt_d;
  logic [11:0] gap_cnt_q, gap_cnt_d;
  logic [5:0]  half_q, half_d;
  logic [2:0]  ch_q, ch_d;
  logic        ad_clk_q, ad_clk_d;
  logic        cs_n_q, cs_n_d;
  logic        din_q, din_d;
  logic [9:0]  shreg_q, shreg_d;
  logic [9:0]  result_q [8];
  logic [9:0]  result_d [8];
  logic        sample_valid_q, sample_valid_d;
  logic [2:0]  sample_ch_q, sample_ch_d;
  logic [9:0]  sample_data_q, sample_data_d;
  logic        scan_done_q, scan_done_d;
  logic        half_evt;

  // Next-state logic: frame sequencing, SPI waveform, capture and commit.
  always_comb begin
    state_d        = state_q;
    hp_cnt_d       = hp_cnt_q;
    gap_cnt_d      = gap_cnt_q;
    half_d         = half_q;
    ch_d           = ch_q;
    ad_clk_d       = ad_clk_q;
    cs_n_d         = cs_n_q;
    din_d          = din_q;
    shreg_d        = shreg_q;
    result_d       = result_q;
    sample_valid_d = 1'b0;
    scan_done_d    = 1'b0;
    sample_ch_d    = sample_ch_q;
    sample_data_d  = sample_data_q;
    half_evt       = (hp_cnt_q == C_HP_LAST);

    unique case (state_q)
      S_IDLE: begin
        if (enable && !C_MASK_EMPTY) begin
          state_d  = S_FRAME;
          cs_n_d   = 1'b0;
          din_d    = 1'b1;
          ad_clk_d = 1'b0;
          hp_cnt_d = 12'd0;
          half_d   = 6'd0;
          shreg_d  = 10'd0;
        end
      end

      S_FRAME: begin
        if (!half_evt) begin
          hp_cnt_d = hp_cnt_q + 12'd1;
        end else begin
          hp_cnt_d = 12'd0;
          half_d   = half_q + 6'd1;
          if (!half_q[0]) begin
            // Rising edge: the ADC shifted its bit out on the previous fall.
            ad_clk_d = 1'b1;
            if (half_q >= C_FIRST_DATA) begin
              shreg_d = {shreg_q[8:0], dout};
            end
          end else begin
            // Falling edge: present the next command bit (SGL, D2, D1, D0).
            ad_clk_d = 1'b0;
            case (half_q)
              6'd1:    din_d = 1'b1;
              6'd3:    din_d = ch_q[2];
              6'd5:    din_d = ch_q[1];
              6'd7:    din_d = ch_q[0];
              default: din_d = 1'b0;
            endcase
            if (half_q == C_LAST_HALF) begin
              cs_n_d            = 1'b1;
              state_d           = S_GAP;
              gap_cnt_d         = 12'd0;
              result_d[ch_q]    = shreg_q;
              sample_valid_d    = 1'b1;
              sample_ch_d       = ch_q;
              sample_data_d     = shreg_q;
              scan_done_d       = (ch_q == C_LAST_CH);
              ch_d              = next_ch(ch_q, CH_MASK);
            end
          end
        end
      end

      S_GAP: begin
        if (gap_cnt_q != C_GAP_LAST) begin
          gap_cnt_d = gap_cnt_q + 12'd1;
        end else if (enable) begin
          state_d  = S_FRAME;
          cs_n_d   = 1'b0;
          din_d    = 1'b1;
          ad_clk_d = 1'b0;
          hp_cnt_d = 12'd0;
          half_d   = 6'd0;
          shreg_d  = 10'd0;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        cs_n_d  = 1'b1;
        din_d   = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any frame immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      hp_cnt_q       <= 12'd0;
      gap_cnt_q      <= 12'd0;
      half_q         <= 6'd0;
      ch_q           <= C_FIRST_CH;
      ad_clk_q       <= 1'b0;
      cs_n_q         <= 1'b1;
      din_q          <= 1'b0;
      shreg_q        <= 10'd0;
      sample_valid_q <= 1'b0;
      sample_ch_q    <= 3'd0;
      sample_data_q  <= 10'd0;
      scan_done_q    <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        result_q[i] <= 10'd0;
      end
    end else begin
      state_q        <= state_d;
      hp_cnt_q       <= hp_cnt_d;
      gap_cnt_q      <= gap_cnt_d;
      half_q         <= half_d;
      ch_q           <= ch_d;
      ad_clk_q       <= ad_clk_d;
      cs_n_q         <= cs_n_d;
      din_q          <= din_d;
      shreg_q        <= shreg_d;
      sample_valid_q <= sample_valid_d;
      sample_ch_q    <= sample_ch_d;
      sample_data_q  <= sample_data_d;
      scan_done_q    <= scan_done_d;
      for (int i = 0; i < 8; i++) begin
        result_q[i] <= result_d[i];
      end
    end
  end

  assign ad_clk       = ad_clk_q;
  assign cs_n         = cs_n_q;
  assign din          = din_q;
  assign sample_valid = sample_valid_q;
  assign sample_ch    = sample_ch_q;
  assign sample_data  = sample_data_q;
  assign scan_done    = scan_done_q;
  // Combinational read: a commit becomes visible the cycle after it happens.
  assign rd_data      = result_q[rd_ch];

endmodule
`default_nettype wire

// File: tb/tb_mcp3008_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_mcp3008_scanner
// Purpose  : Scoreboard bench for mcp3008_scanner with a behavioural MCP3008.
//            Instance A: full mask; B: mask 8'h22; C: empty mask.
// Revision : 1.0  initial release
// ============================================================================
module tb_mcp3008_scanner;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [2:0] ch;
    logic [9:0] data;
    logic       done;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  // ---------------- DUT A: full mask ----------------
  logic       rst_n_a, en_a, ad_clk_a, cs_n_a, din_a, dout_a, sv_a, sd_a;
  logic [2:0] rd_ch_a, sch_a;
  logic [9:0] rd_data_a, sdat_a;

  mcp3008_scanner #(.HALF_PERIOD(25), .GAP_CYCLES(25), .CH_MASK(8'hFF)) u_a (
    .clk(clk), .rst_n(rst_n_a), .enable(en_a), .ad_clk(ad_clk_a), .cs_n(cs_n_a),
    .din(din_a), .dout(dout_a), .rd_ch(rd_ch_a), .rd_data(rd_data_a),
    .sample_valid(sv_a), .sample_ch(sch_a), .sample_data(sdat_a), .scan_done(sd_a)
  );

  // ---------------- DUT B: channels 1 and 5 ----------------
  logic       rst_n_bc, en_b, ad_clk_b, cs_n_b, din_b, sv_b, sd_b;
  logic [2:0] sch_b;
  logic [9:0] rd_data_b, sdat_b;

  mcp3008_scanner #(.HALF_PERIOD(25), .GAP_CYCLES(25), .CH_MASK(8'b0010_0010)) u_b (
    .clk(clk), .rst_n(rst_n_bc), .enable(en_b), .ad_clk(ad_clk_b), .cs_n(cs_n_b),
    .din(din_b), .dout(1'b1), .rd_ch(3'd0), .rd_data(rd_data_b),
    .sample_valid(sv_b), .sample_ch(sch_b), .sample_data(sdat_b), .scan_done(sd_b)
  );

  // ---------------- DUT C: empty mask ----------------
  logic       en_c, ad_clk_c, cs_n_c, din_c, sv_c, sd_c;
  logic [2:0] sch_c;
  logic [9:0] rd_data_c, sdat_c;

  mcp3008_scanner #(.HALF_PERIOD(25), .GAP_CYCLES(25), .CH_MASK(8'h00)) u_c (
    .clk(clk), .rst_n(rst_n_bc), .enable(en_c), .ad_clk(ad_clk_c), .cs_n(cs_n_c),
    .din(din_c), .dout(1'b0), .rd_ch(3'd0), .rd_data(rd_data_c),
    .sample_valid(sv_c), .sample_ch(sch_c), .sample_data(sdat_c), .scan_done(sd_c)
  );

  // ---------------- MCP3008 model for A ----------------
  logic [9:0] adc_val [8];
  int         rk_a = 0;
  int         fk_a = 0;
  logic [4:0] cmd_a = 5'd0;

  // Command decode on rising ad_clk: start, SGL, D2..D0, then din must stay low.
  always @(posedge ad_clk_a or posedge cs_n_a) begin
    if (cs_n_a) begin
      rk_a = 0;
    end else begin
      rk_a = rk_a + 1;
      if (rk_a <= 5) cmd_a = {cmd_a[3:0], din_a};
      if (rk_a == 2) check("a_start_sgl", 32'(cmd_a[1:0]), 32'h3);
      else if (rk_a >= 6) check("a_din_low", 32'(din_a), 32'h0);
    end
  end

  // Data out on falling ad_clk: null bit after fall 6, B9..B0 after falls 7..16.
  always @(negedge ad_clk_a or posedge cs_n_a) begin
    if (cs_n_a) begin
      fk_a   = 0;
      dout_a = 1'b0;
    end else begin
      fk_a = fk_a + 1;
      if (fk_a >= 7 && fk_a <= 16) dout_a = adc_val[cmd_a[2:0]][16 - fk_a];
      else dout_a = 1'b0;
    end
  end

  // Command decode for B.
  int         rk_b = 0;
  logic [4:0] cmd_b = 5'd0;
  always @(posedge ad_clk_b or posedge cs_n_b) begin
    if (cs_n_b) rk_b = 0;
    else begin
      rk_b = rk_b + 1;
      if (rk_b <= 5) cmd_b = {cmd_b[3:0], din_b};
    end
  end

  // ---------------- Monitor A ----------------
  logic cs_prev_a = 1'b1, ad_prev_a = 1'b0, rise_commit_a = 1'b0;
  int   t0_a = 0, rise_a = 0, low_start_a = 0, cs_rise_a = 0, falls_a = 0, sv_cnt_a = 0;

  always @(negedge clk) begin
    exp_t e;
    if (cs_prev_a && !cs_n_a) begin
      falls_a++;
      check("a_start_din", 32'(din_a), 32'h1);
      if (rise_commit_a && (cyc - cs_rise_a) < 200) check("a_gap_len", cyc - cs_rise_a, 25);
      t0_a        = cyc;
      low_start_a = cyc;
    end
    if (!ad_prev_a && ad_clk_a) begin
      if (!cs_n_a) check("a_adclk_low", cyc - low_start_a, 25);
      rise_a = cyc;
    end
    if (ad_prev_a && !ad_clk_a) begin
      if (rst_n_a) check("a_adclk_high", cyc - rise_a, 25);
      low_start_a = cyc;
    end
    if (sv_a) begin
      sv_cnt_a++;
      check("a_commit_time", cyc - t0_a, 850);
      if (q_a.size() == 0) begin
        check("a_unexpected_sample_ch", 32'(sch_a), 32'hFFFF);
      end else begin
        e = q_a.pop_front();
        check("a_sample_ch", 32'(sch_a), 32'(e.ch));
        check("a_sample_data", 32'(sdat_a), 32'(e.data));
        check("a_scan_done", 32'(sd_a), 32'(e.done));
        check("a_addressed_ch", 32'(cmd_a[2:0]), 32'(e.ch));
      end
    end else if (sd_a) begin
      check("a_done_without_sample", 32'(sd_a), 32'h0);
    end
    if (!cs_prev_a && cs_n_a) begin
      cs_rise_a     = cyc;
      rise_commit_a = sv_a;
    end
    cs_prev_a = cs_n_a;
    ad_prev_a = ad_clk_a;
  end

  // ---------------- Monitor B ----------------
  logic cs_prev_b = 1'b1, rise_commit_b = 1'b0;
  int   t0_b = 0, cs_rise_b = 0, sv_cnt_b = 0;

  always @(negedge clk) begin
    exp_t e;
    if (cs_prev_b && !cs_n_b) begin
      if (rise_commit_b && (cyc - cs_rise_b) < 200) check("b_gap_len", cyc - cs_rise_b, 25);
      t0_b = cyc;
    end
    if (sv_b) begin
      sv_cnt_b++;
      check("b_commit_time", cyc - t0_b, 850);
      if (q_b.size() == 0) begin
        check("b_unexpected_sample_ch", 32'(sch_b), 32'hFFFF);
      end else begin
        e = q_b.pop_front();
        check("b_sample_ch", 32'(sch_b), 32'(e.ch));
        check("b_sample_data", 32'(sdat_b), 32'(e.data));
        check("b_scan_done", 32'(sd_b), 32'(e.done));
        check("b_command", 32'(cmd_b), 32'({2'b11, e.ch}));
      end
    end else if (sd_b) begin
      check("b_done_without_sample", 32'(sd_b), 32'h0);
    end
    if (!cs_prev_b && cs_n_b) begin
      cs_rise_b     = cyc;
      rise_commit_b = sv_b;
    end
    cs_prev_b = cs_n_b;
  end

  // ---------------- Monitor C ----------------
  int lows_c = 0, svs_c = 0, sds_c = 0;
  always @(negedge clk) begin
    if (rst_n_bc) begin
      if (!cs_n_c) lows_c++;
      if (sv_c)    svs_c++;
      if (sd_c)    sds_c++;
    end
  end

  // ---------------- Helpers ----------------
  task automatic wait_sv_a(input int target, input int limit);
    int n = 0;
    while (sv_cnt_a < target && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (sv_cnt_a < target) check("a_wait_samples", sv_cnt_a, target);
  endtask

  task automatic wait_frame_a(input int limit);
    int f = falls_a;
    int n = 0;
    while (falls_a == f && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (falls_a == f) check("a_wait_frame", falls_a, f + 1);
  endtask

  task automatic push_a(input int ch);
    q_a.push_back('{ch: 3'(ch), data: adc_val[ch], done: (ch == 7)});
  endtask

  logic b_done = 1'b0, c_done = 1'b0;

  // ---------------- Instance B stimulus ----------------
  initial begin
    int n = 0;
    en_b = 1'b0;
    wait (rst_n_bc === 1'b1);
    q_b.push_back('{ch: 3'd1, data: 10'h3FF, done: 1'b0});
    q_b.push_back('{ch: 3'd5, data: 10'h3FF, done: 1'b1});
    q_b.push_back('{ch: 3'd1, data: 10'h3FF, done: 1'b0});
    q_b.push_back('{ch: 3'd5, data: 10'h3FF, done: 1'b1});
    q_b.push_back('{ch: 3'd1, data: 10'h3FF, done: 1'b0});
    en_b = 1'b1;
    while (sv_cnt_b < 5 && n < 6000) begin
      @(negedge clk);
      n++;
    end
    if (sv_cnt_b < 5) check("b_wait_samples", sv_cnt_b, 5);
    en_b   = 1'b0;
    b_done = 1'b1;
  end

  // ---------------- Instance C stimulus ----------------
  initial begin
    en_c = 1'b0;
    wait (rst_n_bc === 1'b1);
    en_c = 1'b1;
    repeat (10000) @(negedge clk);
    check("c_cs_low_cycles", lows_c, 0);
    check("c_sample_valid_pulses", svs_c, 0);
    check("c_scan_done_pulses", sds_c, 0);
    check("c_cs_n", 32'(cs_n_c), 32'h1);
    c_done = 1'b1;
  end

  // ---------------- Instance A stimulus ----------------
  initial begin
    int n;
    rst_n_a  = 1'b0;
    rst_n_bc = 1'b0;
    en_a     = 1'b0;
    rd_ch_a  = 3'd0;
    for (int i = 0; i < 8; i++) adc_val[i] = 10'h200 + 10'(i);
    repeat (3) @(negedge clk);

    check("rst_cs_n", 32'(cs_n_a), 32'h1);
    check("rst_ad_clk", 32'(ad_clk_a), 32'h0);
    check("rst_din", 32'(din_a), 32'h0);
    check("rst_sample_valid", 32'(sv_a), 32'h0);
    check("rst_scan_done", 32'(sd_a), 32'h0);
    check("rst_sample_ch", 32'(sch_a), 32'h0);
    check("rst_sample_data", 32'(sdat_a), 32'h0);
    for (int i = 0; i < 8; i++) begin
      rd_ch_a = 3'(i);
      #1;
      check("rst_rd_data", 32'(rd_data_a), 32'h0);
    end

    @(negedge clk);
    rst_n_a  = 1'b1;
    rst_n_bc = 1'b1;

    // Scan 1: each channel returns 10'h200 + ch, channels 0..7 in order.
    for (int i = 0; i < 8; i++) push_a(i);
    en_a = 1'b1;
    wait_sv_a(8, 9000);

    // Scan 2: throttle and battery extremes, then random-access readback.
    adc_val[5] = 10'h3FF;
    adc_val[1] = 10'h001;
    for (int i = 0; i < 8; i++) push_a(i);
    wait_sv_a(16, 9000);
    for (int i = 0; i < 8; i++) begin
      rd_ch_a = 3'(i);
      #1;
      check("a_rd_data", 32'(rd_data_a), 32'(adc_val[i]));
    end

    // Drop enable 300 clks into the ch3 frame: it still commits, then idles.
    for (int i = 0; i < 4; i++) push_a(i);
    wait_sv_a(19, 4000);
    wait_frame_a(200);
    while (cyc < t0_a + 300) @(negedge clk);
    en_a = 1'b0;
    wait_sv_a(20, 1000);
    n = falls_a;
    repeat (1200) @(negedge clk);
    check("a_idle_no_new_frame", falls_a - n, 0);
    check("a_idle_cs_n", 32'(cs_n_a), 32'h1);

    // Re-enable resumes at ch4.
    push_a(4);
    en_a = 1'b1;
    wait_sv_a(21, 1200);

    // Reset 400 clks into the ch5 frame: outputs and results clear at once.
    wait_frame_a(200);
    while (cyc < t0_a + 400) @(negedge clk);
    rst_n_a = 1'b0;
    #1;
    check("arst_cs_n", 32'(cs_n_a), 32'h1);
    check("arst_ad_clk", 32'(ad_clk_a), 32'h0);
    check("arst_din", 32'(din_a), 32'h0);
    for (int i = 0; i < 8; i++) begin
      rd_ch_a = 3'(i);
      #1;
      check("arst_rd_data", 32'(rd_data_a), 32'h0);
    end
    repeat (3) @(negedge clk);
    rst_n_a = 1'b1;

    // Scanning restarts at ch0; the aborted ch5 frame never commits.
    push_a(0);
    wait_sv_a(22, 1200);
    en_a = 1'b0;
    repeat (2000) @(negedge clk);
    check("a_queue_left", q_a.size(), 0);

    n = 0;
    while (!(b_done && c_done) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("bc_finished", 32'({b_done, c_done}), 32'h3);
    check("b_queue_left", q_b.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
